// File: rtl/mult_seq_param_pkg.sv
// Shared types and derived-constant helpers for the parametrised sequential multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic int unsigned num_a_digits(input int unsigned w, input int unsigned a_dig);
    return w / a_dig;
  endfunction

  function automatic int unsigned num_b_digits(input int unsigned w, input int unsigned b_dig);
    return w / b_dig;
  endfunction

  function automatic int unsigned num_steps(input int unsigned w, input int unsigned a_dig,
                                            input int unsigned b_dig);
    return num_a_digits(w, a_dig) * num_b_digits(w, b_dig);
  endfunction

endpackage

// File: rtl/mult_seq_param_if.sv
// Start/busy handshake bundle of the sequential multiplier, width set by W.
interface mult_seq_param_if #(
  parameter int unsigned W = 32
) ();
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (output start, is_signed, a, b, input busy, done, product);
  modport slave  (input start, is_signed, a, b, output busy, done, product);
endinterface

// File: rtl/mult_seq_param_pp_unit.sv
// Combinational A_DIG x B_DIG partial product, zero-extended to 2W and shifted into place.
module mult_pp_unit #(
  parameter int unsigned W     = 32,
  parameter int unsigned A_DIG = 16,
  parameter int unsigned B_DIG = 8,
  parameter int unsigned IW    = 3
) (
  input  logic [A_DIG-1:0] a_dig_i,
  input  logic [B_DIG-1:0] b_dig_i,
  input  logic [IW-1:0]    i_i,
  input  logic [IW-1:0]    j_i,
  output logic [2*W-1:0]   pp_o
);
  logic [2*W-1:0]  prod;
  int unsigned     shamt;

  always_comb begin
    prod  = (2*W)'(a_dig_i) * (2*W)'(b_dig_i);
    shamt = 32'(i_i) * A_DIG + 32'(j_i) * B_DIG;
    pp_o  = prod << shamt;
  end
endmodule

// File: rtl/mult_seq_param.sv
// Sequential W x W multiplier, one digit partial product per cycle.
// Define MULT_SIGNED_EN to enable two's-complement mode and the FIX state.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned A_DIG = 16,
  parameter int unsigned B_DIG = 8
) (
  input logic              clk,
  input logic              reset,
  mult_seq_param_if.slave  bus
);
  localparam int unsigned NA = num_a_digits(W, A_DIG);
  localparam int unsigned N  = num_steps(W, A_DIG, B_DIG);
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2*W-1:0]   product_q, product_d;
  logic             done_q, done_d;
  logic [KW-1:0]    i_idx, j_idx;
  logic [A_DIG-1:0] a_dig;
  logic [B_DIG-1:0] b_dig;
  logic [2*W-1:0]   pp;
`ifdef MULT_SIGNED_EN
  logic             neg_q, neg_d;
`else
  logic             unused_is_signed;
  assign unused_is_signed = bus.is_signed;
`endif

  // Step k walks the a-digits fastest, then advances the b-digit.
  always_comb begin
    i_idx = KW'(k_q % NA);
    j_idx = KW'(k_q / NA);
    a_dig = A_DIG'(a_q >> (32'(i_idx) * A_DIG));
    b_dig = B_DIG'(b_q >> (32'(j_idx) * B_DIG));
  end

  mult_pp_unit #(.W(W), .A_DIG(A_DIG), .B_DIG(B_DIG), .IW(KW)) u_pp (
    .a_dig_i (a_dig),
    .b_dig_i (b_dig),
    .i_i     (i_idx),
    .j_i     (j_idx),
    .pp_o    (pp)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    done_d    = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CALC;
          k_d       = '0;
          product_d = '0;
          a_d       = bus.a;
          b_d       = bus.b;
`ifdef MULT_SIGNED_EN
          neg_d     = 1'b0;
          // -2^(W-1) negates to itself, which read as unsigned is the right magnitude
          if (bus.is_signed) begin
            a_d   = bus.a[W-1] ? -bus.a : bus.a;
            b_d   = bus.b[W-1] ? -bus.b : bus.b;
            neg_d = bus.a[W-1] ^ bus.b[W-1];
          end
`endif
        end
      end
      CALC: begin
        product_d = product_q + pp;
        if (k_q == KW'(N - 1)) begin
`ifdef MULT_SIGNED_EN
          state_d = FIX;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          k_d = k_q + 1'b1;
        end
      end
`ifdef MULT_SIGNED_EN
      FIX: begin
        product_d = neg_q ? -product_q : product_q;
        state_d   = IDLE;
        done_d    = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq_param.sv
// Randomised self-checking bench for mult_seq_param (32-bit default and a 16-bit instance).
module tb_mult_seq_param;
`ifdef MULT_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_seq_param_if #(.W(32)) bus32 ();
  mult_seq_param_if #(.W(16)) bus16 ();

  mult_seq_param #(.W(32), .A_DIG(16), .B_DIG(8)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32));
  mult_seq_param #(.W(16), .A_DIG(8),  .B_DIG(4)) dut16 (.clk(clk), .reset(rst_n), .bus(bus16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
`ifdef MULT_SIGNED_EN
    if (sgn) return 64'(longint'(sa) * longint'(sb));
`endif
    if (sgn && sa == sb) return 64'(a) * 64'(b);
    return 64'(a) * 64'(b);
  endfunction

  task automatic wait_done32(output int n);
    n = 0;
    while (!bus32.done && n < LAT + 4) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // poke: raise start with different operands while busy; it must be ignored
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic poke);
    logic [63:0] exp;
    int n;
    exp = model32(a, b, sgn);
    @(negedge clk);
    bus32.a = a; bus32.b = b; bus32.is_signed = sgn; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    chk("busy32_accept", 64'(bus32.busy), 64'd1);
    if (poke) begin
      @(posedge clk); #1;
      bus32.a = ~a; bus32.b = a ^ b; bus32.is_signed = ~sgn; bus32.start = 1'b1;
      @(posedge clk); #1;
      bus32.start = 1'b0;
      chk("busy32_poke", 64'(bus32.busy), 64'd1);
      wait_done32(n);
      n += 2;
    end else begin
      wait_done32(n);
    end
    chk("lat32", 64'(n), 64'(LAT));
    chk("done32", 64'(bus32.done), 64'd1);
    chk("busy32_end", 64'(bus32.busy), 64'd0);
    chk("prod32", bus32.product, exp);
    @(posedge clk); #1;
    chk("done32_pulse", 64'(bus32.done), 64'd0);
    @(posedge clk); #1;
    chk("hold32", bus32.product, exp);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] exp;
    int n;
    exp = 32'(a) * 32'(b);
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.is_signed = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    chk("busy16_accept", 64'(bus16.busy), 64'd1);
    n = 0;
    while (!bus16.done && n < LAT + 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat16", 64'(n), 64'(LAT));
    chk("busy16_end", 64'(bus16.busy), 64'd0);
    chk("prod16", 64'(bus16.product), 64'(exp));
    @(posedge clk); #1;
    chk("done16_pulse", 64'(bus16.done), 64'd0);
  endtask

  initial begin
    int n, dones;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0;
    bus16.start = 1'b0; bus16.is_signed = 1'b0; bus16.a = '0; bus16.b = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy32", 64'(bus32.busy), 64'd0);
    chk("rst_done32", 64'(bus32.done), 64'd0);
    chk("rst_prod32", bus32.product, 64'd0);
    chk("rst_busy16", 64'(bus16.busy), 64'd0);
    chk("rst_prod16", 64'(bus16.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op32(32'd322979956, 32'd300086550, 1'b0, 1'b0);
    chk("directed32", bus32.product, 64'd96921940715191800);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("max32", bus32.product, 64'hFFFF_FFFE_0000_0001);
`ifdef MULT_SIGNED_EN
    op32(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    chk("neg3x5", bus32.product, 64'hFFFF_FFFF_FFFF_FFF1);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    chk("minxmin", bus32.product, 64'h4000_0000_0000_0000);
`endif
    op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);

    // Back-to-back: start stays high across the done cycle
    @(negedge clk);
    bus32.a = 32'd1000; bus32.b = 32'd3000; bus32.is_signed = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    wait_done32(n);
    chk("b2b_lat1", 64'(n), 64'(LAT));
    chk("b2b_prod1", bus32.product, 64'd3000000);
    bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h0000_0013;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    chk("b2b_busy2", 64'(bus32.busy), 64'd1);
    chk("b2b_clear", bus32.product, 64'd0);
    wait_done32(n);
    chk("b2b_lat2", 64'(n), 64'(LAT));
    chk("b2b_prod2", bus32.product, 64'(32'hDEAD_BEEF) * 64'd19);

    // Abort during CALC
    @(negedge clk);
    bus32.a = 32'hCAFE_F00D; bus32.b = 32'h0BAD_BEEF; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(bus32.busy), 64'd0);
    chk("abort_prod", bus32.product, 64'd0);
    chk("abort_done", 64'(bus32.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
      if (bus32.done) dones++;
    end
    chk("abort_nodone", 64'(dones), 64'd0);
    op32(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b0);

    op16(16'hFFFF, 16'hFFFF);
    chk("max16", 64'(bus16.product), 64'hFFFE_0001);
    for (int t = 0; t < 12; t++) op16(16'($urandom), 16'($urandom));
    for (int t = 0; t < 12; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 4 == 0) ra = 32'h8000_0000 | ra[3:0];
      op32(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
